// File: rtl/seq_bin_to_bcd_if.sv
// Handshake and data bundle between a conversion requester and seq_bin_to_bcd.
// The requester drives start/bin; the converter drives result and status.
interface seq_bin_to_bcd_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  overflow;

  modport master (output start, bin, input bcd, busy, done, overflow);
  modport slave  (input start, bin, output bcd, busy, done, overflow);
endinterface

// File: rtl/seq_bin_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Result and overflow are held in output registers until the next completion.
module seq_bin_to_bcd #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  seq_bin_to_bcd_if.slave  bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [BCD_W-1:0]   r_scratch;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sticky;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;

  logic [BCD_W-1:0]   w_adj;
  logic [BCD_W:0]     w_shifted;
  logic               w_sticky;

  // Add-3 adjust on every digit >= 5, each digit wraps independently
  always_comb begin
    w_adj = '0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end else begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4];
      end
    end
  end

  // Top bit is the bit leaving the scratch register this cycle
  assign w_shifted = {w_adj, r_shift[WIDTH-1]};
  assign w_sticky  = r_sticky | w_shifted[BCD_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_sticky  <= 1'b0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_shift   <= bus.bin;
            r_scratch <= '0;
            r_sticky  <= 1'b0;
            r_cnt     <= CNT_W'(WIDTH);
            r_busy    <= 1'b1;
            r_state   <= SHIFT;
          end
        end
        SHIFT: begin
          r_scratch <= w_shifted[BCD_W-1:0];
          r_shift   <= r_shift << 1;
          r_sticky  <= w_sticky;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_bcd   <= w_shifted[BCD_W-1:0];
            r_ovf   <= w_sticky;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bcd      = r_bcd;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Self-checking bench for seq_bin_to_bcd: default 16/5 instance and an 8/2 instance,
// compared against an arithmetic mod/divide reference.
module tb_seq_bin_to_bcd;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  seq_bin_to_bcd_if #(.WIDTH(16), .DIGITS(5)) bus16 ();
  seq_bin_to_bcd_if #(.WIDTH(8),  .DIGITS(2)) bus8 ();

  seq_bin_to_bcd #(.WIDTH(16), .DIGITS(5)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));
  seq_bin_to_bcd #(.WIDTH(8),  .DIGITS(2)) u_dut8  (.clk(clk), .reset(reset), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int unsigned pow10(input int unsigned digits);
    int unsigned p;
    p = 1;
    for (int i = 0; i < int'(digits); i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned digits);
    int unsigned m;
    logic [31:0] r;
    m = v % pow10(digits);
    r = '0;
    for (int i = 0; i < int'(digits); i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v, input int unsigned digits);
    return v >= pow10(digits);
  endfunction

  // Full conversion on the 16-bit instance; optionally pulses ignored starts mid-flight
  task automatic conv16(input logic [15:0] v, input bit pulse_ign);
    int  k;
    int  nbusy;
    bit  seen;
    bus16.start = 1'b1;
    bus16.bin   = v;
    tick();
    bus16.start = 1'b0;
    bus16.bin   = 16'($urandom);
    k = 0; nbusy = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      if (bus16.busy) nbusy++;
      if (bus16.done) begin
        seen = 1'b1;
      end else begin
        if (pulse_ign && (k == 2 || k == 15)) begin
          bus16.start = 1'b1;
          bus16.bin   = 16'd777;
        end else begin
          bus16.start = 1'b0;
        end
        tick();
        k++;
      end
    end
    bus16.start = 1'b0;
    chk("lat16", 32'(k), 32'd16);
    chk("busy16_cycles", 32'(nbusy), 32'd16);
    chk("bcd16", 32'(bus16.bcd), ref_bcd(32'(v), 5));
    chk("ovf16", 32'(bus16.overflow), 32'(ref_ovf(32'(v), 5)));
    tick();
    chk("done16_pulse", 32'(bus16.done), 32'd0);
    chk("busy16_after", 32'(bus16.busy), 32'd0);
    tick();
    chk("bcd16_hold", 32'(bus16.bcd), ref_bcd(32'(v), 5));
  endtask

  task automatic conv8(input logic [7:0] v);
    int  k;
    bit  seen;
    bus8.start = 1'b1;
    bus8.bin   = v;
    tick();
    bus8.start = 1'b0;
    bus8.bin   = 8'($urandom);
    k = 0; seen = 1'b0;
    while (!seen && k < 30) begin
      if (bus8.done) seen = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    chk("lat8", 32'(k), 32'd8);
    chk("bcd8", 32'(bus8.bcd), ref_bcd(32'(v), 2));
    chk("ovf8", 32'(bus8.overflow), 32'(ref_ovf(32'(v), 2)));
    tick();
    chk("done8_pulse", 32'(bus8.done), 32'd0);
  endtask

  initial begin
    int ndone;
    int k;
    logic [15:0] v1;
    logic [15:0] v2;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus16.start = 1'b0; bus16.bin = '0;
    bus8.start  = 1'b0; bus8.bin  = '0;
    repeat (3) tick();
    chk("rst_bcd", 32'(bus16.bcd), 32'd0);
    chk("rst_busy", 32'(bus16.busy), 32'd0);
    chk("rst_done", 32'(bus16.done), 32'd0);
    chk("rst_ovf", 32'(bus16.overflow), 32'd0);
    reset = 1'b0;
    tick();

    // Directed values on the default instance
    conv16(16'd0, 1'b0);
    conv16(16'd65535, 1'b0);
    conv16(16'd9999, 1'b0);
    conv16(16'd1234, 1'b0);

    // Starts during SHIFT are dropped
    conv16(16'd42, 1'b1);
    repeat (3) tick();
    chk("ign_busy", 32'(bus16.busy), 32'd0);
    chk("ign_bcd", 32'(bus16.bcd), 32'h00042);

    // start held high: next accept exactly 18 edges after the first
    v1 = 16'd31415; v2 = 16'd2718;
    bus16.start = 1'b1;
    bus16.bin   = v1;
    tick();
    repeat (16) tick();
    chk("held_done", 32'(bus16.done), 32'd1);
    chk("held_bcd1", 32'(bus16.bcd), ref_bcd(32'(v1), 5));
    bus16.bin = v2;
    tick();
    chk("held_gap_busy", 32'(bus16.busy), 32'd0);
    tick();
    chk("held_reaccept", 32'(bus16.busy), 32'd1);
    bus16.start = 1'b0;
    k = 0;
    while (!bus16.done && k < 40) begin tick(); k++; end
    chk("held_lat2", 32'(k), 32'd16);
    chk("held_bcd2", 32'(bus16.bcd), ref_bcd(32'(v2), 5));
    repeat (2) tick();

    // Reset aborts a conversion in progress
    conv16(16'd500, 1'b0);
    bus16.start = 1'b1;
    bus16.bin   = 16'd321;
    tick();
    bus16.start = 1'b0;
    repeat (7) tick();
    chk("abort_pre_busy", 32'(bus16.busy), 32'd1);
    chk("abort_pre_bcd", 32'(bus16.bcd), 32'h00500);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_bcd", 32'(bus16.bcd), 32'd0);
    chk("abort_busy", 32'(bus16.busy), 32'd0);
    chk("abort_done", 32'(bus16.done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus16.done || bus16.busy) ndone++;
    end
    chk("abort_quiet", 32'(ndone), 32'd0);
    conv16(16'd321, 1'b0);

    // start coincident with reset is not accepted
    reset = 1'b1;
    bus16.start = 1'b1;
    bus16.bin   = 16'd555;
    tick();
    reset = 1'b0;
    bus16.start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus16.done || bus16.busy) ndone++;
      tick();
    end
    chk("rst_start_ign", 32'(ndone), 32'd0);
    chk("rst_start_bcd", 32'(bus16.bcd), 32'd0);

    // Random values on the default instance
    for (int i = 0; i < 12; i++) conv16(16'($urandom), 1'b0);

    // Narrow instance: overflow and per-conversion flag clear
    conv8(8'd99);
    conv8(8'd100);
    conv8(8'd255);
    conv8(8'd7);
    for (int i = 0; i < 12; i++) conv8(8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_bin_to_bcd.md
Name: seq_bin_to_bcd

Overview:
- Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble).
- Processes one input bit per clock.
- Sits directly upstream of the per-digit 7-segment decoders: each 4-bit field of the bcd output drives one decoder.
- Replaces the combinational divide/modulo conversion where area or timing matters. A start/busy/done handshake lets a counter or display controller request conversions.

Parameters:
- WIDTH, 16, bit width of the binary input.
- DIGITS, 5, number of BCD digits produced. Digit 0 is the least significant.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  conversion request; sampled only in IDLE
- bin  input  WIDTH  binary value; captured on the accepted start edge
- bcd  output  4*DIGITS  result register; bcd[4k+3:4k] = digit k; holds value until next completion
- busy  output  1  high while a conversion is in progress (SHIFT state)
- done  output  1  one-cycle pulse when bcd has just been updated
- overflow  output  1  valid with done; 1 when bin >= 10^DIGITS; held with bcd

Behaviour:
- Reset is synchronous and active-high. It is sampled on the rising edge of clk.
  - On reset: state=IDLE, bcd=0, busy=0, done=0, overflow=0, internal shift, scratch and counter registers cleared.
  - Reset overrides all other activity, including a conversion in progress. A partial result is discarded and bcd reads 0.
- States are IDLE, SHIFT and DONE.
- IDLE:
  - busy=0, done=0.
  - On an edge with start=1:
    - shift register <= bin
    - scratch BCD register (4*DIGITS bits) <= 0
    - sticky overflow flag <= 0
    - counter <= WIDTH
    - go to SHIFT
- SHIFT: busy=1, done=0. On each edge:
  - Form an adjusted scratch value: each 4-bit scratch digit >= 5 has 3 added (mod 16, per digit, no cross-digit carry). All digits adjust in parallel, in the same cycle.
  - Shift {adjusted scratch, shift register} left by 1. The shift register MSB enters scratch bit 0.
  - The bit leaving the top of scratch ORs into the sticky overflow flag.
  - Counter decrements.
  - When the counter is 1 at the edge:
    - load bcd with the post-shift scratch value
    - load overflow with the updated sticky flag
    - go to DONE
- DONE:
  - done=1, busy=0, for exactly one cycle. Unconditional return to IDLE on the next edge.
  - start is ignored in DONE.
- Latency:
  - Accepted start edge at E0; done is high in the cycle following edge E(WIDTH).
  - A new start can be accepted at edge E(WIDTH+2). Throughput is one conversion per WIDTH+2 cycles.
- Handshake and input rules:
  - start while busy=1 or done=1 is ignored, with no queuing.
  - Holding start high continuously gives back-to-back conversions of the bin value present at each IDLE edge.
  - bin changes after the accepted edge do not affect the result.
- Arithmetic:
  - bcd equals bin mod 10^DIGITS, each digit 0..9.
  - overflow=1 iff bin >= 10^DIGITS.
  - With defaults (max 65535 < 100000), overflow is always 0.
- Outputs are registered; no output is combinationally driven from inputs.
- WIDTH=1 is legal: SHIFT lasts one cycle.
- Counter width is clog2(WIDTH+1).

Test Plan:
- Defaults. Reset, then start with bin=16'd0 → done pulse exactly 16 cycles after the start edge, bcd=20'h00000, overflow=0, busy high for 16 cycles.
- Defaults. bin=16'd65535 → bcd=20'h65535, overflow=0. Then bin=16'd9999 → bcd=20'h09999. Then bin=16'd1234 → bcd=20'h01234. bcd holds each value between conversions.
- Defaults. start with bin=16'd42, then pulse start with bin=16'd777 at cycles 3 and 16 after acceptance → both ignored, result 20'h00042. start held high throughout → second conversion begins 18 cycles after the first accept.
- Defaults. Complete bin=16'd500 (bcd=20'h00500). Start bin=16'd321, assert reset at cycle 8 of SHIFT → next cycle bcd=0, busy=0, done=0, state IDLE. No done pulse follows. A fresh start with 321 yields 20'h00321.
- WIDTH=8, DIGITS=2:
  - bin=8'd99 → bcd=8'h99, overflow=0, done 8 cycles after start.
  - bin=8'd100 → bcd=8'h00, overflow=1.
  - bin=8'd255 → bcd=8'h55, overflow=1.
  - bin=8'd7 → overflow=0 (flag cleared per conversion).
- Defaults. Start asserted in the same cycle as reset → ignored; no conversion begins, done stays 0.
